// File: rtl/goertzel_power.sv
// ============================================================================
// Module   : goertzel_power
// Purpose  : Squared-magnitude stage of a Goertzel filter. It captures the
//            final filter state of each block and computes the power with
//            one time-shared multiplier. It also clears the filter for the
//            next block.
// Config   : GOERTZEL_POWER_SAT_EN saturates power_o instead of wrapping.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module goertzel_power #(
  parameter int COEFF           = 0,
  parameter int COEFF_BITS      = 16,
  parameter int DW              = 12,
  parameter int BLOCK_SIZE_POW2 = 8,
  parameter int POWER_DW        = 2*DW+4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_i,
  input  logic [BLOCK_SIZE_POW2-1:0]  count_i,
  input  logic signed [DW+1:0]        s0_i,
  input  logic signed [DW+1:0]        s1_i,
  output logic                        clr_o,
  output logic                        busy_o,
  output logic [POWER_DW-1:0]         power_o,
  output logic                        power_valid_o,
  output logic                        overrun_o
);

  localparam int SW    = DW + 2;
  localparam int PW    = 2*SW;
  localparam int ACC_W = 2*SW + 2;
  localparam int XW    = PW + COEFF_BITS;
  localparam int CW    = (ACC_W > POWER_DW + 1) ? ACC_W : POWER_DW + 1;

  localparam logic signed [COEFF_BITS-1:0] COEFF_S = COEFF_BITS'(COEFF);
  localparam logic [BLOCK_SIZE_POW2-1:0]   LAST_COUNT = '1;
  localparam logic signed [CW-1:0]         POW_LIM = CW'({1'b1, {POWER_DW{1'b0}}});

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SQ0   = 3'd1,
    S_SQ1   = 3'd2,
    S_CROSS = 3'd3,
    S_COEF  = 3'd4,
    S_OUT   = 3'd5
  } state_t;

  state_t                  r_state;
  logic signed [SW-1:0]    r_sa;
  logic signed [SW-1:0]    r_sb;
  logic signed [PW-1:0]    r_p;
  logic signed [PW-1:0]    r_x;
  logic signed [ACC_W-1:0] r_acc;

  logic                    w_block_end;
  logic signed [SW-1:0]    w_op_a;
  logic signed [SW-1:0]    w_op_b;
  logic signed [PW-1:0]    w_prod;
  logic signed [XW-1:0]    w_xc;
  logic signed [ACC_W-1:0] w_term;
  logic [POWER_DW-1:0]     w_pow;

  assign w_block_end = valid_i && (count_i == LAST_COUNT);

  // Operand steering for the single shared multiplier
  always_comb begin
    w_op_a = r_sa;
    w_op_b = r_sb;
    case (r_state)
      S_SQ0:   w_op_b = r_sa;
      S_SQ1:   w_op_a = r_sb;
      default: ;
    endcase
  end

  assign w_prod = w_op_a * w_op_b;
  assign w_xc   = r_x * COEFF_S;
  assign w_term = ACC_W'(w_xc >>> (COEFF_BITS - 2));

  // Negative results are rounding artefacts of the floor shift and clamp to 0
  always_comb begin
    w_pow = '0;
    if (!r_acc[ACC_W-1]) begin
`ifdef GOERTZEL_POWER_SAT_EN
      if (CW'(r_acc) >= POW_LIM)
        w_pow = '1;
      else
        w_pow = POWER_DW'(r_acc);
`else
      w_pow = POWER_DW'(r_acc);
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_sa          <= '0;
      r_sb          <= '0;
      r_p           <= '0;
      r_x           <= '0;
      r_acc         <= '0;
      clr_o         <= 1'b0;
      busy_o        <= 1'b0;
      power_o       <= '0;
      power_valid_o <= 1'b0;
      overrun_o     <= 1'b0;
    end else begin
      clr_o         <= 1'b0;
      power_valid_o <= 1'b0;
      overrun_o     <= w_block_end && (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_block_end) begin
            r_sa    <= s0_i;
            r_sb    <= s1_i;
            clr_o   <= 1'b1;
            busy_o  <= 1'b1;
            r_state <= S_SQ0;
          end
        end
        S_SQ0: begin
          r_p     <= w_prod;
          r_state <= S_SQ1;
        end
        S_SQ1: begin
          r_acc   <= ACC_W'(r_p) + ACC_W'(w_prod);
          r_state <= S_CROSS;
        end
        S_CROSS: begin
          r_x     <= w_prod;
          r_state <= S_COEF;
        end
        S_COEF: begin
          r_acc   <= r_acc - w_term;
          r_state <= S_OUT;
        end
        S_OUT: begin
          power_o       <= w_pow;
          power_valid_o <= 1'b1;
          busy_o        <= 1'b0;
          r_state       <= S_IDLE;
        end
        default: begin
          busy_o  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/goertzel_power.md
# goertzel_power

Downstream stage of the Goertzel filter: waits for the final filter output of each block, latches the two state values, and computes the squared magnitude |X|² = s0² + s1² − COEFF·s0·s1 with one time-shared multiplier. It then pulses a clear to the filter so the next block starts from zero. Its result feeds tone-detection and threshold logic.

## Interface
- COEFF, 0: signed filter coefficient, 2·cos(2πk/N), fixed-point with COEFF_BITS−2 fraction bits (same value the filter uses)
- COEFF_BITS, 16: coefficient width, signed
- DW, 12: filter input sample width; state inputs are SW = DW+2 bits
- BLOCK_SIZE_POW2, 8: block length is 2^BLOCK_SIZE_POW2 samples
- POWER_DW, 2·DW+4: output power width, unsigned

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- valid_i  in  1  filter output valid (one-cycle pulse per sample)
- count_i  in  BLOCK_SIZE_POW2  filter sample count, qualified by valid_i
- s0_i, s1_i  in  SW each, signed  filter state
- clr_o  out  1  one-cycle pulse; clears filter state and count
- busy_o  out  1  computation in progress
- power_o  out  POWER_DW  squared magnitude, held until next result
- power_valid_o  out  1  one-cycle pulse, power_o updated
- overrun_o  out  1  one-cycle pulse, block end arrived while busy

## Operation
- Block end = valid_i && count_i == 2^BLOCK_SIZE_POW2−1. No other valid_i cycles have any effect.
- States: IDLE, SQ0, SQ1, CROSS, COEF, OUT.
- IDLE: on block end, latch s0_i/s1_i into sa/sb, pulse clr_o, go to SQ0.
- SQ0: p ← sa·sa.
- SQ1: acc ← p + sb·sb.
- CROSS: x ← sa·sb.
- COEF: acc ← acc − ((x·COEFF) >>> (COEFF_BITS−2)). The shift is arithmetic and truncates toward −∞.
- OUT: power_o ← conv(acc), power_valid_o ← 1, go to IDLE.
- Widths: products are 2·SW signed. acc is 2·SW+2 signed. The cross-coefficient product is 2·SW+COEFF_BITS before the shift.
- conv: if acc < 0, the result is 0 (rounding artefact). The upper bound is set by the Configuration section.
- Block end while state ≠ IDLE: the sample is ignored, overrun_o is pulsed, clr_o is not issued, and the computation in flight is unaffected.
- Block end in the OUT cycle also counts as busy and is treated as an overrun.
- busy_o = (state ≠ IDLE).

## Timing
- Reset values: clr_o=0, busy_o=0, power_o=0, power_valid_o=0, overrun_o=0. State is IDLE and sa/sb/p/x/acc are 0.
- Reset mid-computation aborts immediately. No power_valid_o or clr_o follows.
- All outputs are registered.
- Block end sampled at edge C:
  - clr_o is high for cycle C..C+1.
  - busy_o is high from C through C+5.
  - power_o/power_valid_o change at edge C+5. power_valid_o is high for exactly one cycle.
- Latency from block-end edge to result is 5 clocks.
- A new block end is accepted at edge C+6 at the earliest.
- Because clr_o clears the filter, its next block end is ≥ 2^BLOCK_SIZE_POW2 samples later, so overrun only occurs when valid_i is misdriven.

## Configuration
- GOERTZEL_POWER_SAT_EN defined:
  - If acc ≥ 2^POWER_DW, power_o = 2^POWER_DW − 1 (all ones).
- Undefined:
  - power_o = acc[POWER_DW−1:0] (wraps).
- The negative clamp to 0 applies in both cases.

## Test plan
- COEFF_BITS=16, COEFF=16384 (1.0). Block end with s0=100, s1=0 → power_o=10000, power_valid_o pulses 5 clocks after capture, clr_o pulses at C.
- Same COEFF, s0=100, s1=100 → 10000. s0=100, s1=−100 → 30000.
- COEFF=0, s0=3, s1=4 → 25. valid_i with count_i ≠ 255 → no clr_o, no output, busy_o stays 0.
- Second block end at C+2 → overrun_o pulse, no clr_o. The first result (10000) is still delivered at C+5.
- Small POWER_DW=8, s0=20, s1=0, COEFF=0 (acc=400): with macro → 255, without → 144.
- Assert rst at C+3 → all outputs 0, no power_valid_o. A fresh block end afterwards computes normally.
